// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: multiplexes instruction fetch and load requests onto one AXI AR/R
// channel with a single outstanding single-beat transaction, LSU priority and IF anti-starvation.
module axi_rd_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    // load port
    input  logic              lsu_req,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [2:0]        lsu_size,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    // AXI read address channel
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]   arid,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    // AXI read data channel
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              busy
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    state_e              state_q, state_d;
    logic                owner_lsu_q;       // 1: transaction belongs to LSU
    logic [ADDR_W-1:0]   addr_q;            // full requester address, aligned on output for IF
    logic [2:0]          size_q;
    logic [CNT_W-1:0]    starve_q;
    logic                if_rvalid_q, lsu_rvalid_q;
    logic [31:0]         if_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;
    logic                if_err_q, lsu_err_q;

    logic                if_starved;
    logic                lsu_wins;
    logic                r_done;

    assign if_starved = if_req && (starve_q == STARVE_LIM);
    assign lsu_wins   = lsu_req && !if_starved;
    assign r_done     = (state_q == DATA) && rvalid && rlast;

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    lsu_gnt = 1'b1;
                    state_d = ADDR;
                end else if (if_req) begin
                    if_gnt  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_lsu_q  <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            starve_q     <= '0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            lsu_rdata_q  <= '0;
            if_err_q     <= 1'b0;
            lsu_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;

            if (lsu_gnt) begin
                owner_lsu_q <= 1'b1;
                addr_q      <= lsu_addr;
                size_q      <= lsu_size;
                // only contended LSU wins count against IF
                if (if_req && (starve_q != STARVE_LIM)) starve_q <= starve_q + 1'b1;
            end else if (if_gnt) begin
                owner_lsu_q <= 1'b0;
                addr_q      <= if_addr;
                size_q      <= 3'b011;
                starve_q    <= '0;
            end

            if (r_done) begin
                if (owner_lsu_q) begin
                    lsu_rvalid_q <= 1'b1;
                    lsu_rdata_q  <= rdata;
                    lsu_err_q    <= (rresp != 2'b00);
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= addr_q[2] ? rdata[63:32] : rdata[31:0];
                    if_err_q    <= (rresp != 2'b00);
                end
            end
        end
    end

    assign araddr     = owner_lsu_q ? addr_q : {addr_q[ADDR_W-1:3], 3'b000};
    assign arid       = {{(ID_W-1){1'b0}}, owner_lsu_q};
    assign arsize     = size_q;
    assign arlen      = 8'd0;
    assign arburst    = 2'b01;
    assign busy       = (state_q != IDLE);
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign lsu_rdata  = lsu_rdata_q;
    assign lsu_err    = lsu_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a cycle table for LSU traffic plus hand sequences
// for IF word select, starvation order, AR stall and mid-transaction reset.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        lsu_req;
    logic [63:0] lsu_addr;
    logic [2:0]  lsu_size;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [63:0] lsu_rdata;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        busy;

    int total = 0;
    int bad   = 0;

    axi_rd_arbiter #(
        .ADDR_W(64), .DATA_W(64), .ID_W(4), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req, lsu_req, arready, rvalid, rlast;
        logic [1:0]  rresp;
        logic [63:0] rdata;
        logic        e_if_gnt, e_lsu_gnt, e_arvalid, e_rready, e_busy;
        logic        e_if_rvalid, e_lsu_rvalid, e_lsu_err;
        logic [63:0] e_lsu_rdata;
    } vec_t;

    vec_t vecs[11];

    localparam logic [63:0] DA = 64'hAAAA_0001_AAAA_0002;
    localparam logic [63:0] DB = 64'hBBBB_0003_BBBB_0004;
    localparam logic [63:0] DC = 64'hCCCC_0005_CCCC_0006;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        lsu_req = 1'b0;
        lsu_addr = '0;
        lsu_size = '0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = '0;
        rresp   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // LSU cycle table: error response, back-to-back grant, AR stall, discarded beat
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,64'd0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,64'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'd2,DA,    1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,64'd0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,DA};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,DA};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,DA};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,DB,    1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,DA};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,DA};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,DC,    1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,DA};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,DC};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,64'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,DC};

        // reset state
        do_reset();
        #1;
        check("rst ctl", {if_gnt, lsu_gnt, arvalid, rready, busy, if_rvalid, lsu_rvalid, if_err, lsu_err}, '0);
        check("rst araddr", araddr, '0);
        check("rst arid", arid, '0);
        check("rst arsize", arsize, '0);
        check("rst if_rdata", if_rdata, '0);
        check("rst lsu_rdata", lsu_rdata, '0);
        check("arlen", arlen, 8'd0);
        check("arburst", arburst, 2'b01);

        lsu_addr = 64'h2000_0013;
        lsu_size = 3'b010;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            if_req  = vecs[i].if_req;
            lsu_req = vecs[i].lsu_req;
            arready = vecs[i].arready;
            rvalid  = vecs[i].rvalid;
            rlast   = vecs[i].rlast;
            rresp   = vecs[i].rresp;
            rdata   = vecs[i].rdata;
            #1;
            check($sformatf("v%0d ctl", i),
                  {if_gnt, lsu_gnt, arvalid, rready, busy, if_rvalid, lsu_rvalid, lsu_err},
                  {vecs[i].e_if_gnt, vecs[i].e_lsu_gnt, vecs[i].e_arvalid, vecs[i].e_rready,
                   vecs[i].e_busy, vecs[i].e_if_rvalid, vecs[i].e_lsu_rvalid, vecs[i].e_lsu_err});
            check($sformatf("v%0d lsu_rdata", i), lsu_rdata, vecs[i].e_lsu_rdata);
            if (vecs[i].e_arvalid) begin
                check($sformatf("v%0d araddr", i), araddr, 64'h2000_0013);
                check($sformatf("v%0d arid", i), arid, 4'd1);
                check($sformatf("v%0d arsize", i), arsize, 3'b010);
            end
        end

        // IF only, upper word select, minimum latency
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h8000_0004;
        arready = 1'b1;
        #1 check("t1 if_gnt@T", if_gnt, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("t1 arvalid@T+1", arvalid, 1'b1);
        check("t1 araddr", araddr, 64'h8000_0000);
        check("t1 arid", arid, 4'd0);
        check("t1 arsize", arsize, 3'b011);
        @(negedge clk);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 64'h1111_2222_3333_4444;
        #1 check("t1 rready@T+2", rready, 1'b1);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        check("t1 rvalid@T+3", {if_rvalid, lsu_rvalid, if_err}, 3'b100);
        check("t1 if_rdata", if_rdata, 32'h1111_2222);

        // contention: expected grant order L L L L I L L L L I
        do_reset();
        for (int g = 0; g < 10; g++) begin
            if (g > 0) @(negedge clk);
            if_req  = 1'b1;
            lsu_req = 1'b1;
            arready = 1'b1;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            #1 check($sformatf("t2 grant%0d", g), {lsu_gnt, if_gnt},
                     (g % 5 == 4) ? 2'b01 : 2'b10);
            @(negedge clk);
            #1 check($sformatf("t2 nogrant%0d", g), {lsu_gnt, if_gnt, arvalid}, 3'b001);
            @(negedge clk);
            rvalid = 1'b1;
            rlast  = 1'b1;
        end
        @(negedge clk);
        idle_inputs();

        // AR stall: address stable and no grant to a new request meanwhile
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h0000_1000;
        #1 check("t3 if_gnt", if_gnt, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if_req   = 1'b0;
            lsu_req  = 1'b1;
            lsu_addr = 64'h3000_0008;
            lsu_size = 3'b011;
            #1;
            check($sformatf("t3 stall%0d", c), {arvalid, lsu_gnt, if_gnt}, 3'b100);
            check($sformatf("t3 araddr%0d", c), araddr, 64'h0000_1000);
            check($sformatf("t3 arid%0d", c), arid, 4'd0);
        end
        @(negedge clk);
        arready = 1'b1;
        #1 check("t3 accept", {arvalid, lsu_gnt}, 2'b10);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        #1 check("t3 data nogrant", {rready, lsu_gnt}, 2'b10);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1 check("t3 pending lsu_gnt", {if_rvalid, lsu_gnt}, 2'b11);
        @(negedge clk);
        idle_inputs();

        // reset while in DATA abandons the transaction
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h0000_0040;
        arready = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        #1 check("t5 in data", rready, 1'b1);
        rst    = 1'b1;
        rvalid = 1'b1;
        rlast  = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h0000_0080;
        #1;
        check("t5 abandoned", {busy, rready, arvalid, if_rvalid, lsu_rvalid}, 5'b0);
        check("t5 regrant", if_gnt, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("t5 arvalid", arvalid, 1'b1);
        check("t5 araddr", araddr, 64'h0000_0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
